// File: rtl/sdm_pkg.sv
// sdm_pkg: shared state type, full-scale helper, clamp function and LFSR constants
// for the sigma-delta modulator (dither logic in the top is gated by SDM_DITHER_EN).
package sdm_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        RECOVER = 1'b1
    } sdm_state_t;

    localparam int SAT_MAX_W = 64;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Feedback taps for x^16 + x^14 + x^13 + x^11 + 1, shifting towards the MSB.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef struct packed {
        logic signed [SAT_MAX_W-1:0] value;
        logic                        hit;
    } sat_t;

    function automatic int fs_of(input int in_w);
        return 1 << (in_w - 1);
    endfunction

    function automatic sat_t sat(input logic signed [SAT_MAX_W-1:0] value, input int acc_w);
        logic signed [SAT_MAX_W-1:0] hi;
        logic signed [SAT_MAX_W-1:0] lo;
        sat_t                        r;
        hi      = (64'sd1 <<< (acc_w - 1)) - 64'sd1;
        lo      = -hi - 64'sd1;
        r.value = value;
        r.hit   = 1'b0;
        if (value > hi) begin
            r.value = hi;
            r.hit   = 1'b1;
        end else if (value < lo) begin
            r.value = lo;
            r.hit   = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sdm_sat_integrator.sv
// sdm_sat_integrator: W-bit signed accumulator with a (W+2)-bit internal sum that is
// clamped before storage; nxt/sat_hit expose the clamped candidate combinationally.
module sdm_sat_integrator
    import sdm_pkg::*;
#(
    parameter int W = 24
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic                clr,
    input  logic signed [W:0]   inc,
    output logic signed [W-1:0] acc,
    output logic signed [W-1:0] nxt,
    output logic                sat_hit
);
    logic signed [W+1:0] sum;
    sat_t                clamped;

    assign sum = (W+2)'(acc) + (W+2)'(inc);

    always_comb begin
        clamped = sat(SAT_MAX_W'(sum), W);
        nxt     = W'(clamped.value);
        sat_hit = clamped.hit;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= nxt;
        end
    end

endmodule

// File: rtl/sigma_delta_modulator.sv
// sigma_delta_modulator: second-order single-bit modulator with saturating integrators
// and overload recovery; define SDM_DITHER_EN to add LFSR dither at the quantiser.
//   state   | meaning
//   RUN     | noise shaping active, counting consecutive saturated cycles
//   RECOVER | integrators held at zero, bit_out toggles as a zero-mean idle tone
module sigma_delta_modulator
    import sdm_pkg::*;
#(
    parameter int IN_W           = 16,
    parameter int ACC_W          = 24,
    parameter int OVL_LIMIT      = 8,
    parameter int RECOVER_CYCLES = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clk_enable,
    input  logic signed [IN_W-1:0] input_data,
    output logic                   bit_out,
    output logic                   ce_out,
    output logic                   overload,
    output logic                   recovering
);
    localparam int OVL_W = $clog2(OVL_LIMIT + 1);
    localparam int REC_W = $clog2(RECOVER_CYCLES + 1);
    localparam logic signed [ACC_W:0] FS_V = (ACC_W+1)'(fs_of(IN_W));

    sdm_state_t              state, state_nxt;
    logic [OVL_W-1:0]        ovl_cnt, ovl_cnt_nxt;
    logic [REC_W-1:0]        rec_cnt, rec_cnt_nxt;
    logic                    bit_nxt, ovl_nxt, int_en, int_clr, q_pos;
    logic signed [ACC_W-1:0] i1, i2, i1n, i2n;
    logic                    sat1, sat2;
    logic signed [ACC_W:0]   v, inc1, inc2, q_val;
    logic signed [4:0]       d;

    assign v    = bit_out ? FS_V : -FS_V;
    assign inc1 = (ACC_W+1)'(input_data) - v;
    assign inc2 = (ACC_W+1)'(i1) - (v <<< 1);

    sdm_sat_integrator #(.W(ACC_W)) u_int1 (
        .clk(clk), .reset(reset), .en(int_en), .clr(int_clr),
        .inc(inc1), .acc(i1), .nxt(i1n), .sat_hit(sat1)
    );

    sdm_sat_integrator #(.W(ACC_W)) u_int2 (
        .clk(clk), .reset(reset), .en(int_en), .clr(int_clr),
        .inc(inc2), .acc(i2), .nxt(i2n), .sat_hit(sat2)
    );

`ifdef SDM_DITHER_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr <= LFSR_SEED;
        end else if (clk_enable) begin
            lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
        end
    end

    assign d = $signed({1'b0, lfsr[3:0]}) - 5'sd8;
`else
    assign d = '0;
`endif

    // Dither only biases the decision; i2 stores the undithered value.
    assign q_val = (ACC_W+1)'(i2n) + (ACC_W+1)'(d);
    assign q_pos = ~q_val[ACC_W];

    always_comb begin
        state_nxt   = state;
        ovl_cnt_nxt = ovl_cnt;
        rec_cnt_nxt = rec_cnt;
        bit_nxt     = bit_out;
        ovl_nxt     = 1'b0;
        int_en      = 1'b0;
        int_clr     = 1'b0;
        if (clk_enable) begin
            unique case (state)
                RUN: begin
                    if ((sat1 || sat2) && (ovl_cnt == OVL_W'(OVL_LIMIT - 1))) begin
                        ovl_nxt     = 1'b1;
                        int_clr     = 1'b1;
                        rec_cnt_nxt = '0;
                        ovl_cnt_nxt = OVL_W'(OVL_LIMIT);
                        state_nxt   = RECOVER;
                    end else begin
                        ovl_cnt_nxt = (sat1 || sat2) ? ovl_cnt + 1'b1 : '0;
                        int_en      = 1'b1;
                        bit_nxt     = q_pos;
                    end
                end
                RECOVER: begin
                    bit_nxt     = ~bit_out;
                    rec_cnt_nxt = rec_cnt + 1'b1;
                    if (rec_cnt == REC_W'(RECOVER_CYCLES - 1)) begin
                        ovl_cnt_nxt = '0;
                        state_nxt   = RUN;
                    end
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= RUN;
            ovl_cnt  <= '0;
            rec_cnt  <= '0;
            bit_out  <= 1'b0;
            overload <= 1'b0;
            ce_out   <= 1'b0;
        end else begin
            state    <= state_nxt;
            ovl_cnt  <= ovl_cnt_nxt;
            rec_cnt  <= rec_cnt_nxt;
            bit_out  <= bit_nxt;
            overload <= ovl_nxt;
            ce_out   <= clk_enable;
        end
    end

    assign recovering = (state == RECOVER);

endmodule
